// File: rtl/csea_mp_seq.sv
// -----------------------------------------------------------------------------
// csea_mp_seq
// Multi-precision add/subtract sequencer. One external 16-bit combinational
// adder is reused: the operands are processed one 16-bit word per cycle,
// least significant word first. The carry between words is held in a register.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start_valid  request strobe          start_ready  sequencer can accept
//   A, B         W-bit operands, captured on accept only
//   Cin          carry-in for add (ignored when Sub=1)
//   Sub          1: A - B, 0: A + B + Cin
//   add_A/add_B/add_Cin   word operands and carry driven to the external adder
//                         (add_B is already complemented when subtracting)
//   add_Sum/add_Cout      combinational result of the external adder
//   Sum, Cout, Ovf        result registers (Cout=1 on subtract means no borrow)
//   res_valid    result available        res_ready    consumer takes result
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. start_ready is 1 only in IDLE. res_valid is 1 only in DONE, and
// Sum/Cout/Ovf stay stable until the transfer. Only start_valid raised while
// start_ready=1 is accepted; valid seen at any other time is ignored.
// -----------------------------------------------------------------------------
module csea_mp_seq #(
  parameter  int WORDS = 4,
  localparam int W     = 16 * WORDS,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          Cin,
  input  logic          Sub,
  output logic [15:0]   add_A,
  output logic [15:0]   add_B,
  output logic          add_Cin,
  input  logic [15:0]   add_Sum,
  input  logic          add_Cout,
  output logic [W-1:0]  Sum,
  output logic          Cout,
  output logic          Ovf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // State and datapath registers
  state_t           state_q,       state_d;
  logic [W-1:0]     op_a_q,        op_a_d;
  logic [W-1:0]     op_b_q,        op_b_d;
  logic             sub_q,         sub_d;
  logic [IDX_W-1:0] idx_q,         idx_d;
  logic             carry_q,       carry_d;
  logic [W-1:0]     sum_q,         sum_d;
  logic             cout_q,        cout_d;
  logic             ovf_q,         ovf_d;
  logic             res_valid_q,   res_valid_d;
  logic             start_ready_q, start_ready_d;

  // Word slices of the operand registers and the adder drive
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic [15:0] add_a_w;
  logic [15:0] add_b_w;
  logic        add_cin_w;

  always_comb begin
    a_word = op_a_q[16*idx_q +: 16];
    // Subtraction is A + ~B + 1: the inversion is applied here, and the +1
    // comes in through the carry register preset at accept time.
    b_word = op_b_q[16*idx_q +: 16] ^ {16{sub_q}};
  end

  // The adder inputs are only meaningful in RUN. They stay at zero otherwise,
  // so the shared adder sees quiet inputs while idle.
  always_comb begin
    add_a_w   = 16'h0000;
    add_b_w   = 16'h0000;
    add_cin_w = 1'b0;
    if (state_q == ST_RUN) begin
      add_a_w   = a_word;
      add_b_w   = b_word;
      add_cin_w = carry_q;
    end
  end

  assign add_A   = add_a_w;
  assign add_B   = add_b_w;
  assign add_Cin = add_cin_w;

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    sub_d         = sub_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    ovf_d         = ovf_q;
    res_valid_d   = res_valid_q;
    start_ready_d = start_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          op_a_d        = A;
          op_b_d        = B;
          sub_d         = Sub;
          idx_d         = '0;
          carry_d       = Sub ? 1'b1 : Cin;
          state_d       = ST_RUN;
          start_ready_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Words that are not yet written keep their old contents. Sum is only
        // defined to the consumer while res_valid is 1.
        sum_d[16*idx_q +: 16] = add_Sum;
        carry_d               = add_Cout;
        if (idx_q == LAST_IDX) begin
          cout_d      = add_Cout;
          // Signed overflow: the operands as the adder sees them (B already
          // inverted for subtract) have equal signs and the result sign differs.
          ovf_d       = (op_a_q[W-1] == add_b_w[15]) &&
                        (add_Sum[15] != op_a_q[W-1]);
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          res_valid_d   = 1'b0;
          state_d       = ST_IDLE;
          start_ready_d = 1'b1;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
      end
    endcase
  end

  // All state in one register block. Reset drops any operation in progress
  // and clears the result, so a partial Sum is never presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sub_q         <= 1'b0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      sub_q         <= sub_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      ovf_q         <= ovf_d;
      res_valid_q   <= res_valid_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign Ovf         = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_csea_mp_seq.sv
module tb_csea_mp_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  // Clock / reset
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Cin;
  logic          Sub;
  logic [15:0]   add_A;
  logic [15:0]   add_B;
  logic          add_Cin;
  logic [15:0]   add_Sum;
  logic          add_Cout;
  logic [W-1:0]  Sum;
  logic          Cout;
  logic          Ovf;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    dbg_state;

  // External 16-bit adder
  assign {add_Cout, add_Sum} = {1'b0, add_A} + {1'b0, add_B} + {16'h0000, add_Cin};

  csea_mp_seq #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .Sub         (Sub),
    .add_A       (add_A),
    .add_B       (add_B),
    .add_Cin     (add_Cin),
    .add_Sum     (add_Sum),
    .add_Cout    (add_Cout),
    .Sum         (Sum),
    .Cout        (Cout),
    .Ovf         (Ovf),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .dbg_state   (dbg_state)
  );

  // Counters and per-operation captures
  int          checks = 0;
  int          errors = 0;
  logic        cin_seq [WORDS];
  logic [15:0] bw_seq  [WORDS];
  logic        rv_seq  [WORDS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, capture the adder drive for each RUN cycle and stop at
  // the negedge after edge k+WORDS, where res_valid must already be 1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    @(negedge clk);
    check("start_ready_before_accept", start_ready, 1'b1);
    A           = a;
    B           = b;
    Cin         = cin;
    Sub         = sub;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    // Operands may change freely after the accept edge.
    A   = {$urandom, $urandom};
    B   = {$urandom, $urandom};
    Cin = 1'($urandom_range(0, 1));
    Sub = 1'($urandom_range(0, 1));
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      cin_seq[i] = add_Cin;
      bw_seq[i]  = add_B;
      rv_seq[i]  = res_valid;
    end
    @(negedge clk);
    check("res_valid_latency", res_valid, 1'b1);
    check("done_start_ready", start_ready, 1'b0);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("post_hs_res_valid", res_valid, 1'b0);
    check("post_hs_start_ready", start_ready, 1'b1);
    check("post_hs_state", dbg_state, 2'd0);
  endtask

  function automatic logic rv_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < WORDS; i++) r = r | rv_seq[i];
    return r;
  endfunction

  initial begin
    reset_n     = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    A           = '0;
    B           = '0;
    Cin         = 1'b0;
    Sub         = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_sum", Sum, 64'h0);
    check("rst_cout", Cout, 1'b0);
    check("rst_ovf", Ovf, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);
    check("rst_add_a_idle", add_A, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: all-ones + 1, carry ripples through every word
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    check("t1_sum", Sum, 64'h0);
    check("t1_cout", Cout, 1'b1);
    check("t1_ovf", Ovf, 1'b0);
    check("t1_cin0", cin_seq[0], 1'b0);
    check("t1_cin1", cin_seq[1], 1'b1);
    check("t1_cin2", cin_seq[2], 1'b1);
    check("t1_cin3", cin_seq[3], 1'b1);
    check("t1_no_early_valid", rv_any(), 1'b0);
    handshake();

    // 2: 5 - 7 = -2, borrow so Cout=0
    run_op(64'h5, 64'h7, 1'b0, 1'b1);
    check("t2_sum", Sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_cout", Cout, 1'b0);
    check("t2_ovf", Ovf, 1'b0);
    check("t2_bw0", bw_seq[0], 16'hFFF8);
    check("t2_bw3", bw_seq[3], 16'hFFFF);
    check("t2_cin0", cin_seq[0], 1'b1);
    handshake();

    // 3: carry-in propagates from word 0 into word 1
    run_op(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0);
    check("t3_sum", Sum, 64'h0000_0000_0001_0000);
    check("t3_cout", Cout, 1'b0);
    check("t3_cin1", cin_seq[1], 1'b1);
    check("t3_cin2", cin_seq[2], 1'b0);
    handshake();

    // Extra: subtract without borrow
    run_op(64'h0001_0000_0000_0000, 64'h1, 1'b1, 1'b1);
    check("tx_sum", Sum, 64'h0000_FFFF_FFFF_FFFF);
    check("tx_cout", Cout, 1'b1);
    check("tx_ovf", Ovf, 1'b0);
    handshake();

    // 4: max positive + 1 overflows
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    check("t4_sum", Sum, 64'h8000_0000_0000_0000);
    check("t4_ovf", Ovf, 1'b1);
    check("t4_cout", Cout, 1'b0);

    // 5: result held while res_ready=0, start_valid in DONE ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        A           = 64'h1;
        B           = 64'h1;
        start_valid = 1'b1;
      end
      if (i == 4) start_valid = 1'b0;
      @(negedge clk);
      check("t5_hold_sum", Sum, 64'h8000_0000_0000_0000);
      check("t5_hold_cout", Cout, 1'b0);
      check("t5_hold_ovf", Ovf, 1'b1);
      check("t5_hold_valid", res_valid, 1'b1);
      check("t5_hold_start_ready", start_ready, 1'b0);
      check("t5_hold_state", dbg_state, 2'd2);
    end
    handshake();
    run_op(64'h0000_0000_0002_0003, 64'h0000_0000_0004_0005, 1'b0, 1'b0);
    check("t5_next_sum", Sum, 64'h0000_0000_0006_0008);
    check("t5_next_cout", Cout, 1'b0);
    handshake();

    // 6: reset during RUN at idx=2
    @(negedge clk);
    A           = 64'h1111_2222_3333_4444;
    B           = 64'h0;
    Cin         = 1'b0;
    Sub         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_idx2_add_a", add_A, 16'h2222);
    check("t6_idx2_state", dbg_state, 2'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_sum", Sum, 64'h0);
    check("t6_rst_res_valid", res_valid, 1'b0);
    check("t6_rst_state", dbg_state, 2'd0);
    check("t6_rst_start_ready", start_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    check("t6_fresh_sum", Sum, 64'h2345_6789_ABCD_F001);
    check("t6_fresh_cout", Cout, 1'b0);
    check("t6_fresh_ovf", Ovf, 1'b0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csea_mp_seq.md
Name: csea_mp_seq

Overview:
Multi-precision add/subtract sequencer that time-shares one external 16-bit carry-select adder to add or subtract operands of 16*WORDS bits. It walks the operands one 16-bit word per cycle, least significant word first, and chains the carry between words through a register. It sits between a valid/ready request interface and a single combinational 16-bit adder instance. It also generates the adder's operand, carry-in and complement controls.

Parameters:
WORDS, 4, number of 16-bit words per operand; total width W = 16*WORDS; legal range 2..16.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
start_valid  input  1  request strobe.
start_ready  output  1  sequencer can accept a request.
A  input  W  operand A; sampled only on accept.
B  input  W  operand B; sampled only on accept.
Cin  input  1  carry-in for add; ignored when Sub=1.
Sub  input  1  1 = compute A - B; 0 = compute A + B + Cin.
add_A  output  16  word to the external adder, A input.
add_B  output  16  word to the external adder, B input; already complemented when subtracting.
add_Cin  output  1  carry-in to the external adder.
add_Sum  input  16  sum returned by the external adder; combinational from add_A, add_B and add_Cin.
add_Cout  input  1  carry-out returned by the external adder.
Sum  output  W  result register.
Cout  output  1  final carry-out; for subtract, Cout=1 means no borrow.
Ovf  output  1  two's-complement signed overflow of the full-width result.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE immediately.
  - Sum=0, Cout=0, Ovf=0, res_valid=0.
  - Operand registers, word index and carry register clear to 0.
  - start_ready=1 while in IDLE after reset.
  - Reset asserted mid-operation abandons the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1; add_A, add_B and add_Cin are driven 0.
  - On start_valid=1: register A, B and Sub; set idx=0; set carry=Sub ? 1 : Cin; move to RUN.
- RUN:
  - start_ready=0.
  - add_A = opA[16*idx +: 16].
  - add_B = opB[16*idx +: 16] XOR {16{Sub_r}}.
  - add_Cin = carry.
  - Each edge: Sum[16*idx +: 16] <= add_Sum; carry <= add_Cout; idx <= idx+1.
  - At the edge where idx==WORDS-1:
    - Cout <= add_Cout.
    - Ovf <= (opA[W-1] == add_B[15]) && (add_Sum[15] != opA[W-1]).
    - Move to DONE.
- DONE:
  - res_valid=1; Sum, Cout and Ovf are held stable.
  - On res_ready=1: res_valid drops and state returns to IDLE.
  - start_ready=0 in DONE. A new request can be accepted at the earliest one cycle after the result handshake.
- Latency: request accepted at edge k; res_valid=1 after edge k+WORDS; throughput is one operation per WORDS+2 cycles.
- Sum words not yet written during RUN hold their previous values. Consumers must read Sum only while res_valid=1.
- start_valid outside IDLE is ignored; A, B, Cin and Sub may change freely outside the accept edge.
- idx width is ceil(log2(WORDS)). No wrap-around occurs because RUN exits at WORDS-1.

Test Plan:
1. WORDS=4, Sub=0, Cin=0, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> after 4 RUN cycles: Sum=0, Cout=1, Ovf=0; add_Cin sequence 0,1,1,1.
2. Sub=1, A=0x0000_0000_0000_0005, B=0x0000_0000_0000_0007 -> Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0; add_B word0=0xFFF8, add_Cin initial 1.
3. Sub=0, Cin=1, A=0x0000_0000_0000_FFFF, B=0 -> Sum=0x0000_0000_0001_0000, Cout=0; checks carry chaining across words.
4. Sub=0, Cin=0, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=0x8000_0000_0000_0000, Ovf=1, Cout=0.
5. Hold res_ready=0 for 10 cycles after res_valid -> Sum, Cout and Ovf are unchanged; start_ready=0; a start_valid pulse in DONE is ignored; result handshake, then next request accepted.
6. Assert reset_n=0 while idx=2 in RUN -> Sum=0, res_valid=0, state IDLE without waiting for a clock edge; after release start_ready=1 and a fresh add completes correctly.
